act_stream_ctrl: RTL
====================

# act_stream_ctrl

Sequencer that streams a vector of Q4.12 pre-activations from a source buffer through the pipelined `sigmoid` unit and writes the activations into a destination buffer. Sits directly upstream of `sigmoid`, driving its `din`/`en`, and consumes its `dout`/`valid`. The LSTM gate logic triggers it once per gate vector with `start` and waits for `done`.

## Interface
- `ADDR_W`, default 6: buffer address width. Maximum vector length is 2^ADDR_W.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `len`  in  ADDR_W+1  vector length, 0..2^ADDR_W; latched on an accepted `start`.
- `src_base`  in  ADDR_W  first source address; latched on an accepted `start`.
- `dst_base`  in  ADDR_W  first destination address; latched on an accepted `start`.
- `busy`  out  1  high from the cycle after an accepted start until the last write completes.
- `done`  out  1  one-cycle completion pulse.
- `src_rd_en`  out  1  source RAM read strobe; read data returns 1 cycle later.
- `src_addr`  out  ADDR_W  source read address.
- `src_rd_data`  in  16  source RAM data, Q4.12 signed.
- `act_en`  out  1  drives `sigmoid.en`.
- `act_din`  out  16  drives `sigmoid.din`.
- `act_dout`  in  16  from `sigmoid.dout`, Q4.12 (0x0000..0x1000 nominal).
- `act_valid`  in  1  from `sigmoid.valid`.
- `dst_wr_en`  out  1  destination RAM write strobe.
- `dst_addr`  out  ADDR_W  destination write address.
- `dst_data`  out  16  destination write data.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN and FINISH. Reset enters IDLE.
- IDLE:
  - `start`=1 latches `len`, `src_base` and `dst_base`, and clears `rd_cnt` and `wr_cnt`.
  - With `len`≠0 the FSM moves to ISSUE. With `len`=0 it moves to FINISH.
- ISSUE:
  - Each cycle: `src_rd_en`=1, `src_addr`=src_base+rd_cnt, then `rd_cnt`++.
  - When `rd_cnt` reaches len−1 the FSM issues that read and moves to DRAIN.
- Sigmoid issue:
  - `act_en` is `src_rd_en` delayed one register.
  - `act_din` = `src_rd_data` (combinational pass-through, aligned to `act_en`).
  - No gaps occur: one element is issued per cycle.
- Write-back, in any non-IDLE state:
  - `act_valid`=1 registers `dst_wr_en`=1, `dst_addr`=dst_base+wr_cnt, and `dst_data`=act_dout (processed per Configuration). Then `wr_cnt`++.
  - `act_valid` seen in IDLE is ignored. These are stale results left in the sigmoid pipeline after a reset.
- DRAIN: when the write with `wr_cnt`=len−1 is registered, the FSM moves to FINISH.
- FINISH: `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- `start` in any state other than IDLE is ignored. The latched parameters do not change mid-run.
- Address arithmetic is modulo 2^ADDR_W. For example, base+offset wraps from 63 to 0 with ADDR_W=6.
- Counters are ADDR_W+1 bits, so `len`=2^ADDR_W completes correctly.
- Reset mid-run: all outputs return to their reset values immediately. Partial writes already issued stay in the RAM, and there is no `done`.

## Timing
- Reset values: `busy`, `done`, `src_rd_en`, `act_en` and `dst_wr_en` are 0. `src_addr`, `act_din` (with `src_rd_data` ignored), `dst_addr` and `dst_data` are 0.
- `act_din` is forced to 0 when `act_en`=0.
- Latency budget:
  - Read: 1 cycle.
  - `sigmoid`: `en`→`valid` is 5 cycles.
  - Write register: 1 cycle.
- With `start` accepted in cycle 0:
  - `src_rd_en` is high in cycles 1..len.
  - `act_en` is high in cycles 2..len+1.
  - `act_valid` is high in cycles 7..len+6.
  - `dst_wr_en` is high in cycles 8..len+7.
  - `done` is high in cycle len+8.
  - `busy` is high in cycles 1..len+7.
- `len`=0: `done` in cycle 1, `busy` never asserts, and no reads or writes occur.
- Throughput: one element per cycle. A new `start` is accepted in the cycle after `done`.

## Configuration
- `ACT_STREAM_CLAMP_EN` defined:
  - `dst_data` = act_dout clamped to 0x0000..0x1000.
  - Values with bit15=1 become 0x0000. Values > 0x1000 become 0x1000.
- `ACT_STREAM_CLAMP_EN` undefined: `dst_data` = act_dout unmodified. There is no clamp logic.

## Test plan
- len=4, src_base=0, dst_base=8, source holds 0x0000, 0x1000, 0xF000 and 0x7FFF:
  - `dst_wr_en` is high in cycles 8..11 at addresses 8..11.
  - `done` is high in cycle 12.
  - The data is the sigmoid outputs: ≈0x0802, ≈0xBxx, ≈0x4xx and 0x1000.
- len=0: `done` in cycle 1, with zero `src_rd_en` and zero `dst_wr_en` pulses.
- len=64, ADDR_W=6, src_base=60, dst_base=62:
  - Read addresses run 60..63, 0..59.
  - Write addresses run 62, 63, 0..61.
  - `done` is high in cycle 72.
- `start` pulsed in cycle 3 of a len=4 run: it is ignored. The latched parameters are unchanged and there is a single `done`.
- `rst_n` is dropped in cycle 5 of a len=8 run, then released:
  - All outputs are 0 immediately.
  - Late `act_valid` pulses produce no `dst_wr_en`.
  - A fresh len=2 start completes normally.
- Force `act_dout`=0x1010 and 0xFFF8:
  - With CLAMP_EN: 0x1000 and 0x0000.
  - Without CLAMP_EN: passed through unchanged.

Source files
------------

// File: rtl/act_stream_ctrl.sv
// act_stream_ctrl: streams a Q4.12 vector from a source buffer through the
// pipelined sigmoid unit and writes the activations to a destination buffer.
// Optional feature macro: ACT_STREAM_CLAMP_EN (clamps written data to 0x0000..0x1000).
module act_stream_ctrl #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              src_rd_en_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [15:0]       src_rd_data_i,
    output logic              act_en_o,
    output logic [15:0]       act_din_o,
    input  logic [15:0]       act_dout_i,
    input  logic              act_valid_i,
    output logic              dst_wr_en_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [15:0]       dst_data_o
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                src_rd_en_q, src_rd_en_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic                act_en_q;
    logic                dst_wr_en_q, dst_wr_en_d;
    logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
    logic [DATA_W-1:0]   dst_data_q, dst_data_d;
    logic [DATA_W-1:0]   act_proc;

`ifdef ACT_STREAM_CLAMP_EN
    // Clamp the sigmoid result into the nominal 0.0..1.0 Q4.12 range
    always_comb begin
        act_proc = act_dout_i;
        if (act_dout_i[DATA_W-1]) begin
            act_proc = '0;
        end else if (act_dout_i > DATA_W'(16'h1000)) begin
            act_proc = DATA_W'(16'h1000);
        end
    end
`else
    assign act_proc = act_dout_i;
`endif

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            src_rd_en_q <= 1'b0;
            src_addr_q  <= '0;
            act_en_q    <= 1'b0;
            dst_wr_en_q <= 1'b0;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            src_base_q  <= src_base_d;
            dst_base_q  <= dst_base_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            src_rd_en_q <= src_rd_en_d;
            src_addr_q  <= src_addr_d;
            act_en_q    <= src_rd_en_q;
            dst_wr_en_q <= dst_wr_en_d;
            dst_addr_q  <= dst_addr_d;
            dst_data_q  <= dst_data_d;
        end
    end

    // Next-state, read issue and write-back logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        src_base_d  = src_base_q;
        dst_base_d  = dst_base_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        src_rd_en_d = 1'b0;
        src_addr_d  = src_addr_q;
        dst_wr_en_d = 1'b0;
        dst_addr_d  = dst_addr_q;
        dst_data_d  = dst_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d      = len_i;
                    src_base_d = src_base_i;
                    dst_base_d = dst_base_i;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    if (len_i == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        // First read goes out on the same edge that leaves IDLE
                        src_rd_en_d = 1'b1;
                        src_addr_d  = src_base_i;
                        rd_cnt_d    = CNT_W'(1);
                        state_d     = (len_i == CNT_W'(1)) ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                src_rd_en_d = 1'b1;
                src_addr_d  = src_base_q + ADDR_W'(rd_cnt_q);
                rd_cnt_d    = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == CNT_W'(len_q - CNT_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // wr_cnt reaches len once the final write is on the outputs
                if (wr_cnt_q == len_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results arriving in IDLE are stale pipeline contents and are dropped
        if (act_valid_i && (state_q != S_IDLE)) begin
            dst_wr_en_d = 1'b1;
            dst_addr_d  = dst_base_q + ADDR_W'(wr_cnt_q);
            dst_data_d  = act_proc;
            wr_cnt_d    = wr_cnt_q + CNT_W'(1);
        end
    end

    // Status flags follow the state being entered
    always_comb begin
        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d = (state_d == S_FINISH);
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign src_rd_en_o = src_rd_en_q;
    assign src_addr_o  = src_addr_q;
    assign act_en_o    = act_en_q;
    assign act_din_o   = act_en_q ? src_rd_data_i : '0;
    assign dst_wr_en_o = dst_wr_en_q;
    assign dst_addr_o  = dst_addr_q;
    assign dst_data_o  = dst_data_q;

endmodule
